cdb_rr_scheduler: RTL and testbench
===================================

// Module: cdb_rr_scheduler
// PURPOSE
//  Clocked round-robin scheduler for the Common Data Bus (CDB) of the Tomasulo core.
//  Sits between the functional units (ADD/MUL reservation-station outputs) and CDB consumers
//  (register status table, reservation stations). Grants at most one unit per cycle and
//  broadcasts the tag and result as a registered one-cycle pulse. Tag 0 = free register.
// PARAMETERS
//  NUM_UNITS  4   number of requesting functional units (2..7)
//  DATA_W     16  result width
//  TAG_W      3   tag width; unit i broadcasts tag i+1
// PORTS
//  Clock      in   1                 rising-edge clock
//  Reset      in   1                 reset Reset, synchronous, active-high
//  Req        in   NUM_UNITS         unit i has a finished result pending
//  Req_data   in   NUM_UNITS*DATA_W  result of unit i, bits [i*DATA_W +: DATA_W]
//  CDB_stall  in   1                 consumer busy; no grant this cycle
//  Grant      out  NUM_UNITS         one-hot, one-cycle pulse: unit's result is on CDB
//  CDB_valid  out  1                 broadcast valid this cycle
//  CDB_tag    out  TAG_W             tag of broadcasting unit (i+1); 0 when idle
//  CDB_data   out  DATA_W            broadcast result; 0 when idle
// BEHAVIOUR
//  - All outputs registered. Reset: Grant=0, CDB_valid=0, CDB_tag=0, CDB_data=0,
//    last-grant pointer = NUM_UNITS-1 (unit 0 has top priority first).
//  - Eligible(i) = Req[i] & ~Grant[i] (a unit granted this cycle is masked for one cycle).
//  - Each edge, if ~CDB_stall and any eligible: winner = first eligible index searching
//    ptr+1, ptr+2, ... modulo NUM_UNITS (wrap past NUM_UNITS-1 to 0). Next cycle:
//    Grant=onehot(winner), CDB_valid=1, CDB_tag=winner+1, CDB_data=Req_data[winner]
//    sampled at that edge; ptr <= winner.
//  - Otherwise (stall or no eligible): Grant=0, CDB_valid=0, tag/data=0, ptr unchanged.
//  - Latency: Req sampled high at edge t -> broadcast during cycle t..t+1 (1 cycle).
//  - Handshake: unit holds Req and Req_data stable until it sees Grant; it deasserts Req
//    by the next edge. Earliest re-request of same unit: 2 cycles after previous grant.
//  - Throughput: one broadcast per cycle; back-to-back broadcasts from different units allowed.
//  - Stall asserted while CDB_valid high does not cancel the current pulse; it only
//    blocks the next grant. Requests are never dropped while stalled.
//  - Req[i] falling without a grant (flush) is legal; unit simply stops being eligible.
//  - Reset mid-broadcast: outputs and pointer return to reset values at that edge.
//  - Single requester: granted every other cycle if it re-requests immediately.
// CONFIGURATION
//  CDB_STATS_EN defined: adds outputs Busy_count[15:0] (cycles with CDB_valid=1) and
//    Conflict_count[15:0] (edges where >1 unit eligible and not stalled); both
//    saturate at 16'hFFFF, cleared by Reset.
//  CDB_STATS_EN undefined: those ports and counters do not exist; scheduling identical.
// TESTING
//  1 Reset 2 cycles -> all outputs 0; then Req=4'b1111 -> first Grant=4'b0001, tag 3'd1.
//  2 Req[1]=1, Req_data unit1=16'h00AB -> next cycle Grant=4'b0010, CDB_valid=1,
//    CDB_tag=3'd2, CDB_data=16'h00AB for exactly one cycle.
//  3 All units request continuously (re-raise after grant) -> tags 1,2,3,4,1,... with
//    no repeat while others wait; check wrap 4 -> 1.
//  4 Last grant unit0, then Req[0] and Req[2] together -> unit2 granted, unit0 next cycle.
//  5 Req[3] pending, CDB_stall=1 for 3 cycles -> CDB_valid=0 throughout; tag 3'd4 on
//    edge after stall falls.
//  6 Reset asserted while CDB_valid=1 -> outputs 0 next cycle; with CDB_STATS_EN,
//    counters read 0 and after 5 broadcasts Busy_count=16'd5.

Source files
------------

// File: rtl/cdb_rr_scheduler.sv
// Round-robin scheduler for the Common Data Bus of the Tomasulo core.
// Grants at most one functional unit per cycle and broadcasts its tag and result
// as a registered one-cycle pulse. Unit i broadcasts tag i+1; tag 0 means idle.
//
// Ports:
//   Clock           rising-edge clock
//   Reset           synchronous, active-high reset
//   Req             per-unit "finished result pending"
//   Req_data        per-unit results, unit i at [i*DATA_W +: DATA_W]
//   CDB_stall       consumers busy; blocks the next grant
//   Grant           one-hot grant pulse (registered)
//   CDB_valid       broadcast valid (registered)
//   CDB_tag         broadcasting tag, 0 when idle (registered)
//   CDB_data        broadcast result, 0 when idle (registered)
//   Busy_count      cycles with CDB_valid=1, saturating    (CDB_STATS_EN only)
//   Conflict_count  unstalled edges with >1 eligible unit  (CDB_STATS_EN only)
//
// Optional feature macro: CDB_STATS_EN adds the two statistics counters.
module cdb_rr_scheduler #(
  parameter int unsigned NUM_UNITS = 4,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned TAG_W     = 3
) (
  input  logic                        Clock,
  input  logic                        Reset,
  input  logic [NUM_UNITS-1:0]        Req,
  input  logic [NUM_UNITS*DATA_W-1:0] Req_data,
  input  logic                        CDB_stall,
  output logic [NUM_UNITS-1:0]        Grant,
  output logic                        CDB_valid,
  output logic [TAG_W-1:0]            CDB_tag,
`ifdef CDB_STATS_EN
  output logic [DATA_W-1:0]           CDB_data,
  output logic [15:0]                 Busy_count,
  output logic [15:0]                 Conflict_count
`else
  output logic [DATA_W-1:0]           CDB_data
`endif
);

  localparam int unsigned PTR_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
  localparam int unsigned CNT_W = 16;

  logic [NUM_UNITS-1:0] grant_q, grant_d;
  logic                 valid_q, valid_d;
  logic [TAG_W-1:0]     tag_q,   tag_d;
  logic [DATA_W-1:0]    data_q,  data_d;
  logic [PTR_W-1:0]     ptr_q,   ptr_d;

  logic [NUM_UNITS-1:0] elig_c;
  logic [PTR_W-1:0]     idx_c;
  logic [PTR_W-1:0]     winner_c;
  logic                 found_c;

  // Winner search: first eligible unit after the last grant, wrapping modulo NUM_UNITS.
  // A unit granted last cycle is masked so it cannot win back-to-back.
  always_comb begin
    elig_c   = Req & ~grant_q;
    idx_c    = '0;
    winner_c = '0;
    found_c  = 1'b0;
    for (int k = 1; k <= int'(NUM_UNITS); k++) begin
      idx_c = PTR_W'((32'(ptr_q) + 32'(k)) % NUM_UNITS);
      if (!found_c && elig_c[idx_c]) begin
        found_c  = 1'b1;
        winner_c = idx_c;
      end
    end
  end

  // Next broadcast and pointer update.
  always_comb begin
    grant_d = '0;
    valid_d = 1'b0;
    tag_d   = '0;
    data_d  = '0;
    ptr_d   = ptr_q;
    if (!CDB_stall && found_c) begin
      grant_d = NUM_UNITS'(1) << winner_c;
      valid_d = 1'b1;
      tag_d   = TAG_W'(winner_c) + TAG_W'(1);
      data_d  = Req_data[32'(winner_c)*DATA_W +: DATA_W];
      ptr_d   = winner_c;
    end
  end

  // Broadcast registers; the pointer resets so unit 0 has first priority.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      grant_q <= '0;
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
      ptr_q   <= PTR_W'(NUM_UNITS - 1);
    end else begin
      grant_q <= grant_d;
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
      ptr_q   <= ptr_d;
    end
  end

  assign Grant     = grant_q;
  assign CDB_valid = valid_q;
  assign CDB_tag   = tag_q;
  assign CDB_data  = data_q;

`ifdef CDB_STATS_EN
  logic [CNT_W-1:0] busy_q, busy_d;
  logic [CNT_W-1:0] conf_q, conf_d;

  // Saturating utilisation and contention counters.
  always_comb begin
    busy_d = busy_q;
    conf_d = conf_q;
    if (valid_q && (busy_q != '1)) begin
      busy_d = busy_q + CNT_W'(1);
    end
    if (!CDB_stall && ($countones(elig_c) > 1) && (conf_q != '1)) begin
      conf_d = conf_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      busy_q <= '0;
      conf_q <= '0;
    end else begin
      busy_q <= busy_d;
      conf_q <= conf_d;
    end
  end

  assign Busy_count     = busy_q;
  assign Conflict_count = conf_q;
`endif

endmodule

// File: tb/tb_cdb_rr_scheduler.sv
// Directed self-checking bench for cdb_rr_scheduler (NUM_UNITS=4, DATA_W=16, TAG_W=3).
module tb_cdb_rr_scheduler;

  logic        Clock;
  logic        Reset;
  logic [3:0]  Req;
  logic [63:0] Req_data;
  logic        CDB_stall;
  logic [3:0]  Grant;
  logic        CDB_valid;
  logic [2:0]  CDB_tag;
  logic [15:0] CDB_data;
`ifdef CDB_STATS_EN
  logic [15:0] Busy_count;
  logic [15:0] Conflict_count;
`endif

  int checks = 0;
  int errors = 0;

  cdb_rr_scheduler dut (
    .Clock          (Clock),
    .Reset          (Reset),
    .Req            (Req),
    .Req_data       (Req_data),
    .CDB_stall      (CDB_stall),
    .Grant          (Grant),
    .CDB_valid      (CDB_valid),
    .CDB_tag        (CDB_tag),
`ifdef CDB_STATS_EN
    .CDB_data       (CDB_data),
    .Busy_count     (Busy_count),
    .Conflict_count (Conflict_count)
`else
    .CDB_data       (CDB_data)
`endif
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  localparam logic [63:0] DATA_DEF = {16'h1003, 16'h1002, 16'h1001, 16'h1000};

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // Expected broadcast for a given one-hot grant (0 = idle).
  task automatic expect_bc(input string name, input logic [3:0] g,
                           input logic [2:0] tag, input logic [15:0] data);
    chk({name, ".grant"}, 32'(Grant),     32'(g));
    chk({name, ".valid"}, 32'(CDB_valid), 32'(g != 4'b0));
    chk({name, ".tag"},   32'(CDB_tag),   32'(tag));
    chk({name, ".data"},  32'(CDB_data),  32'(data));
  endtask

  initial begin
    Reset = 1'b1; Req = '0; Req_data = DATA_DEF; CDB_stall = 1'b0;
    #1;

    // Reset for two cycles: everything idle.
    tick(); tick();
    expect_bc("reset", 4'b0000, 3'd0, 16'h0);
`ifdef CDB_STATS_EN
    chk("reset.busy", 32'(Busy_count), 32'd0);
    chk("reset.conf", 32'(Conflict_count), 32'd0);
`endif

    // All units requesting continuously: 1,2,3,4 then wrap to 1,2.
    Reset = 1'b0; Req = 4'b1111;
    tick(); expect_bc("rr1", 4'b0001, 3'd1, 16'h1000);
    tick(); expect_bc("rr2", 4'b0010, 3'd2, 16'h1001);
    tick(); expect_bc("rr3", 4'b0100, 3'd3, 16'h1002);
    tick(); expect_bc("rr4", 4'b1000, 3'd4, 16'h1003);
    tick(); expect_bc("rr_wrap", 4'b0001, 3'd1, 16'h1000);
    tick(); expect_bc("rr6", 4'b0010, 3'd2, 16'h1001);
    Req = 4'b0000;
    tick(); expect_bc("rr_idle", 4'b0000, 3'd0, 16'h0);

    // Single request from unit 1 with a specific payload: exactly one pulse.
    Req = 4'b0010; Req_data[31:16] = 16'h00AB;
    tick(); expect_bc("u1", 4'b0010, 3'd2, 16'h00AB);
    Req = 4'b0000; Req_data = DATA_DEF;
    tick(); expect_bc("u1_end", 4'b0000, 3'd0, 16'h0);

    // Last grant unit 0, then units 0 and 2 together: 2 first, then 0.
    Req = 4'b0001;
    tick(); expect_bc("u0", 4'b0001, 3'd1, 16'h1000);
    Req = 4'b0101;
    tick(); expect_bc("u0u2_a", 4'b0100, 3'd3, 16'h1002);
    Req = 4'b0001;
    tick(); expect_bc("u0u2_b", 4'b0001, 3'd1, 16'h1000);
    Req = 4'b0000;
    tick(); expect_bc("u0u2_idle", 4'b0000, 3'd0, 16'h0);

    // Unit 3 pending under a 3-cycle stall; granted on the edge after stall falls.
    Req = 4'b1000; CDB_stall = 1'b1;
    tick(); expect_bc("stall1", 4'b0000, 3'd0, 16'h0);
    tick(); expect_bc("stall2", 4'b0000, 3'd0, 16'h0);
    tick(); expect_bc("stall3", 4'b0000, 3'd0, 16'h0);
    CDB_stall = 1'b0;
    tick(); expect_bc("stall_rel", 4'b1000, 3'd4, 16'h1003);
    Req = 4'b0000;
    tick(); expect_bc("stall_idle", 4'b0000, 3'd0, 16'h0);

    // Stall raised while a pulse is on the bus: pulse unaffected, next grant blocked.
    Req = 4'b0011;
    tick(); expect_bc("vstall_a", 4'b0001, 3'd1, 16'h1000);
    Req = 4'b0010; CDB_stall = 1'b1;
    tick(); expect_bc("vstall_b", 4'b0000, 3'd0, 16'h0);
    CDB_stall = 1'b0;
    tick(); expect_bc("vstall_c", 4'b0010, 3'd2, 16'h1001);
    Req = 4'b0000;
    tick(); expect_bc("vstall_idle", 4'b0000, 3'd0, 16'h0);

    // Reset mid-broadcast, then pointer restarts at unit 0.
    Req = 4'b1111;
    tick(); expect_bc("pre_rst", 4'b0100, 3'd3, 16'h1002);
    Reset = 1'b1;
    tick(); expect_bc("mid_rst", 4'b0000, 3'd0, 16'h0);
`ifdef CDB_STATS_EN
    chk("mid_rst.busy", 32'(Busy_count), 32'd0);
    chk("mid_rst.conf", 32'(Conflict_count), 32'd0);
`endif
    Reset = 1'b0;
    tick(); expect_bc("post_rst1", 4'b0001, 3'd1, 16'h1000);
    tick(); expect_bc("post_rst2", 4'b0010, 3'd2, 16'h1001);
    tick(); expect_bc("post_rst3", 4'b0100, 3'd3, 16'h1002);
    tick(); expect_bc("post_rst4", 4'b1000, 3'd4, 16'h1003);
    tick(); expect_bc("post_rst5", 4'b0001, 3'd1, 16'h1000);
    Req = 4'b0000;
    tick(); expect_bc("post_rst_idle", 4'b0000, 3'd0, 16'h0);
`ifdef CDB_STATS_EN
    chk("stats.busy", 32'(Busy_count), 32'd5);
    chk("stats.conf", 32'(Conflict_count), 32'd5);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
